// File: rtl/mem_ctrl.sv
// -----------------------------------------------------------------------------
// mem_ctrl
//   Memory-side stage behind the CPU core. Accepts level-held Read / write_mem
//   requests, latches MAR and write data, waits WAIT_CYCLES extra cycles, then
//   performs one access against an internal word-addressed RAM. Read data is
//   returned on a registered bus, and mem_ready is held high until both
//   request levels drop.
//
// Ports
//   clk        in   1   system clock, rising edge
//   reset      in   1   asynchronous, active-high reset
//   Read       in   1   read request level
//   write_mem  in   1   write request level
//   MAR        in   32  word address
//   wdata      in   32  write data
//   rdata      out  32  registered read data
//   mem_ready  out  1   access complete (high while in DONE)
//   addr_err   out  1   sticky error: out-of-range MAR or both requests high
// -----------------------------------------------------------------------------
module mem_ctrl #(
    parameter int    DEPTH       = 512,
    parameter int    ADDR_W      = 9,
    parameter int    WAIT_CYCLES = 2,
    parameter string INIT_FILE   = ""
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        Read,
    input  logic        write_mem,
    input  logic [31:0] MAR,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        mem_ready,
    output logic        addr_err
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

    logic [31:0]       r_ram [0:DEPTH-1];

    state_t            r_state;
    logic [3:0]        r_cnt;
    logic [31:0]       r_mar;
    logic [31:0]       r_wdata;
    logic              r_op_wr;
    logic [31:0]       r_rdata;
    logic              r_ready;
    logic              r_err;

    logic              w_in_range;
    logic              w_access;
    logic              w_ram_we;
    logic [ADDR_W-1:0] w_idx;
    logic [31:0]       w_ram_word;

    assign w_idx      = r_mar[ADDR_W-1:0];
    assign w_in_range = (r_mar < 32'(DEPTH));
    assign w_ram_word = r_ram[w_idx];

    // The access happens on the edge that leaves BUSY with the counter spent.
    assign w_access   = (r_state == S_BUSY) && (r_cnt == 4'd0);

    // Reset is folded in so an edge coinciding with reset cannot commit a
    // write that the FSM has already abandoned.
    assign w_ram_we   = w_access && r_op_wr && w_in_range && !reset;

    // RAM has no reset: contents survive a controller reset.
    always_ff @(posedge clk) begin
        if (w_ram_we) begin
            r_ram[w_idx] <= r_wdata;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_cnt   <= 4'd0;
            r_mar   <= 32'd0;
            r_wdata <= 32'd0;
            r_op_wr <= 1'b0;
            r_rdata <= 32'd0;
            r_ready <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_ready <= 1'b0;
                    if (Read || write_mem) begin
                        r_mar   <= MAR;
                        r_wdata <= wdata;
                        r_op_wr <= write_mem;
                        r_cnt   <= WAIT_INIT;
                        if (Read && write_mem) begin
                            // Conflicting request: no RAM access, report and finish.
                            r_err   <= 1'b1;
                            r_ready <= 1'b1;
                            r_state <= S_DONE;
                        end else begin
                            r_state <= S_BUSY;
                        end
                    end
                end

                S_BUSY: begin
                    if (r_cnt != 4'd0) begin
                        r_cnt <= r_cnt - 4'd1;
                    end else begin
                        if (!w_in_range) begin
                            r_err <= 1'b1;
                        end
                        if (!r_op_wr) begin
                            r_rdata <= w_in_range ? w_ram_word : 32'd0;
                        end
                        r_ready <= 1'b1;
                        r_state <= S_DONE;
                    end
                end

                S_DONE: begin
                    // Held request levels must fall before another access can start.
                    if (!Read && !write_mem) begin
                        r_ready <= 1'b0;
                        r_state <= S_IDLE;
                    end
                end

                default: begin
                    r_ready <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign rdata     = r_rdata;
    assign mem_ready = r_ready;
    assign addr_err  = r_err;

endmodule

// File: tb/tb_mem_ctrl.sv
module tb_mem_ctrl;

    localparam int WC    = 2;
    localparam int DEPTH = 512;

    logic        clk = 1'b0;
    logic        reset;
    logic        Read, write_mem;
    logic [31:0] MAR, wdata;
    logic [31:0] rdata;
    logic        mem_ready, addr_err;

    logic        Read0, write0;
    logic [31:0] MAR0, wdata0;
    logic [31:0] rdata0;
    logic        ready0, err0;

    int n_cmp  = 0;
    int n_fail = 0;

    // Reference model: word store with known flags, expected rdata and error.
    logic [31:0] m_mem   [0:DEPTH-1];
    bit          m_known [0:DEPTH-1];
    logic [31:0] m_rdata;
    bit          m_rknown;
    logic        m_err;

    always #5 clk = ~clk;

    mem_ctrl #(.DEPTH(DEPTH), .ADDR_W(9), .WAIT_CYCLES(WC), .INIT_FILE("")) dut (
        .clk(clk), .reset(reset), .Read(Read), .write_mem(write_mem),
        .MAR(MAR), .wdata(wdata), .rdata(rdata), .mem_ready(mem_ready), .addr_err(addr_err)
    );

    mem_ctrl #(.DEPTH(DEPTH), .ADDR_W(9), .WAIT_CYCLES(0), .INIT_FILE("")) dut0 (
        .clk(clk), .reset(reset), .Read(Read0), .write_mem(write0),
        .MAR(MAR0), .wdata(wdata0), .rdata(rdata0), .mem_ready(ready0), .addr_err(err0)
    );

    // Drives one request on the WC=2 instance; returns edges until mem_ready (0 = timeout).
    task automatic acc(input bit wr, input bit rd, input logic [31:0] addr, input logic [31:0] data,
                       input bit scramble, input bit drop, output int lat);
        MAR = addr; wdata = data; Read = rd; write_mem = wr;
        lat = 0;
        for (int n = 1; n <= 40; n++) begin
            @(posedge clk); #1;
            if (n == 1 && scramble) begin MAR = $urandom; wdata = $urandom; end
            if (n == 1 && drop) begin Read = 1'b0; write_mem = 1'b0; end
            if (mem_ready) begin lat = n; break; end
        end
        Read = 1'b0; write_mem = 1'b0;
    endtask

    task automatic acc0(input bit wr, input logic [31:0] addr, input logic [31:0] data, output int lat);
        MAR0 = addr; wdata0 = data; Read0 = !wr; write0 = wr;
        lat = 0;
        for (int n = 1; n <= 40; n++) begin
            @(posedge clk); #1;
            if (ready0) begin lat = n; break; end
        end
        Read0 = 1'b0; write0 = 1'b0;
    endtask

    // Model update for a completed single-op access.
    task automatic model_op(input bit wr, input logic [31:0] addr, input logic [31:0] data);
        bit inr;
        inr = (addr < DEPTH);
        if (!inr) m_err = 1'b1;
        if (wr) begin
            if (inr) begin m_mem[addr] = data; m_known[addr] = 1'b1; end
        end else begin
            m_rdata  = inr ? m_mem[addr] : 32'd0;
            m_rknown = inr ? m_known[addr] : 1'b1;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        Read = 0; write_mem = 0; Read0 = 0; write0 = 0;
        m_rdata = 32'd0; m_rknown = 1'b1; m_err = 1'b0;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        n_cmp++; if (rdata !== 32'd0) begin n_fail++; $display("FAIL reset_rdata got=%h exp=0", rdata); end
        n_cmp++; if (mem_ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready got=%b exp=0", mem_ready); end
        n_cmp++; if (addr_err !== 1'b0) begin n_fail++; $display("FAIL reset_err got=%b exp=0", addr_err); end
    endtask

    task automatic test_write_read();
        int lat;
        acc(1, 0, 32'h10, 32'hDEADBEEF, 0, 0, lat); model_op(1, 32'h10, 32'hDEADBEEF);
        n_cmp++; if (lat != WC + 2) begin n_fail++; $display("FAIL wr_latency got=%0d exp=%0d", lat, WC + 2); end
        @(posedge clk); #1;
        n_cmp++; if (mem_ready !== 1'b0) begin n_fail++; $display("FAIL wr_idle_ready got=%b exp=0", mem_ready); end
        n_cmp++; if (rdata !== 32'd0) begin n_fail++; $display("FAIL wr_rdata_unchanged got=%h exp=0", rdata); end
        acc(0, 1, 32'h10, 32'h0, 0, 0, lat); model_op(0, 32'h10, 32'h0);
        n_cmp++; if (lat != WC + 2) begin n_fail++; $display("FAIL rd_latency got=%0d exp=%0d", lat, WC + 2); end
        n_cmp++; if (rdata !== 32'hDEADBEEF) begin n_fail++; $display("FAIL rd_data got=%h exp=deadbeef", rdata); end
        @(posedge clk); #1;
    endtask

    task automatic test_hold();
        int lat;
        MAR = 32'h10; Read = 1'b1; lat = 0;
        for (int n = 1; n <= 40; n++) begin
            @(posedge clk); #1;
            if (mem_ready) begin lat = n; break; end
        end
        n_cmp++; if (lat != WC + 2) begin n_fail++; $display("FAIL hold_latency got=%0d exp=%0d", lat, WC + 2); end
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            n_cmp++; if (mem_ready !== 1'b1) begin n_fail++; $display("FAIL hold_ready cyc=%0d got=%b exp=1", c, mem_ready); end
        end
        n_cmp++; if (rdata !== 32'hDEADBEEF) begin n_fail++; $display("FAIL hold_rdata got=%h exp=deadbeef", rdata); end
        Read = 1'b0;
        @(posedge clk); #1;
        n_cmp++; if (mem_ready !== 1'b0) begin n_fail++; $display("FAIL hold_release got=%b exp=0", mem_ready); end
    endtask

    task automatic test_random();
        int lat;
        logic [31:0] a, d;
        bit wr, scr, drp;
        for (int i = 0; i < 16; i++) begin
            a = 32'(i * 32 + 5); d = $urandom;
            acc(1, 0, a, d, 0, 0, lat); model_op(1, a, d);
            @(posedge clk); #1;
        end
        for (int i = 0; i < 40; i++) begin
            wr  = $urandom_range(0, 1);
            a   = ($urandom_range(0, 9) == 0) ? 32'(DEPTH + $urandom_range(0, 300)) : 32'($urandom_range(0, 15) * 32 + 5);
            d   = $urandom;
            scr = $urandom_range(0, 1);
            drp = $urandom_range(0, 3) == 0;
            acc(wr, !wr, a, d, scr, drp, lat); model_op(wr, a, d);
            n_cmp++; if (lat != WC + 2) begin n_fail++; $display("FAIL rnd_latency i=%0d got=%0d exp=%0d", i, lat, WC + 2); end
            if (m_rknown) begin
                n_cmp++; if (rdata !== m_rdata) begin n_fail++; $display("FAIL rnd_rdata i=%0d addr=%h got=%h exp=%h", i, a, rdata, m_rdata); end
            end
            n_cmp++; if (addr_err !== m_err) begin n_fail++; $display("FAIL rnd_err i=%0d got=%b exp=%b", i, addr_err, m_err); end
            @(posedge clk); #1;
            n_cmp++; if (mem_ready !== 1'b0) begin n_fail++; $display("FAIL rnd_idle i=%0d got=%b exp=0", i, mem_ready); end
        end
    endtask

    task automatic test_out_of_range();
        int lat;
        acc(1, 0, 32'h0, 32'hCAFE0000, 0, 0, lat); model_op(1, 32'h0, 32'hCAFE0000);
        @(posedge clk); #1;
        do_reset(); #1;
        n_cmp++; if (addr_err !== 1'b0) begin n_fail++; $display("FAIL oor_err_cleared got=%b exp=0", addr_err); end
        acc(1, 0, 32'h200, 32'h1234, 0, 0, lat); model_op(1, 32'h200, 32'h1234);
        n_cmp++; if (addr_err !== 1'b1) begin n_fail++; $display("FAIL oor_wr_err got=%b exp=1", addr_err); end
        @(posedge clk); #1;
        acc(0, 1, 32'h10, 0, 0, 0, lat); model_op(0, 32'h10, 0);
        @(posedge clk); #1;
        acc(0, 1, 32'h200, 0, 0, 0, lat); model_op(0, 32'h200, 0);
        n_cmp++; if (rdata !== 32'd0) begin n_fail++; $display("FAIL oor_rd_data got=%h exp=0", rdata); end
        n_cmp++; if (lat != WC + 2) begin n_fail++; $display("FAIL oor_latency got=%0d exp=%0d", lat, WC + 2); end
        @(posedge clk); #1;
        acc(0, 1, 32'h0, 0, 0, 0, lat); model_op(0, 32'h0, 0);
        n_cmp++; if (rdata !== 32'hCAFE0000) begin n_fail++; $display("FAIL oor_ram0 got=%h exp=cafe0000", rdata); end
        @(posedge clk); #1;
    endtask

    task automatic test_both();
        int lat;
        do_reset(); #1;
        acc(0, 1, 32'h10, 0, 0, 0, lat); model_op(0, 32'h10, 0);
        @(posedge clk); #1;
        acc(1, 1, 32'h10, 32'h55555555, 0, 0, lat);
        n_cmp++; if (lat != 1) begin n_fail++; $display("FAIL both_latency got=%0d exp=1", lat); end
        n_cmp++; if (addr_err !== 1'b1) begin n_fail++; $display("FAIL both_err got=%b exp=1", addr_err); end
        n_cmp++; if (rdata !== m_rdata) begin n_fail++; $display("FAIL both_rdata got=%h exp=%h", rdata, m_rdata); end
        @(posedge clk); #1;
        acc(0, 1, 32'h10, 0, 0, 0, lat); model_op(0, 32'h10, 0);
        n_cmp++; if (rdata !== m_rdata) begin n_fail++; $display("FAIL both_nowrite got=%h exp=%h", rdata, m_rdata); end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_midaccess();
        int lat;
        acc(1, 0, 32'h20, 32'h11112222, 0, 0, lat); model_op(1, 32'h20, 32'h11112222);
        @(posedge clk); #1;
        MAR = 32'h20; wdata = 32'hA5A5A5A5; write_mem = 1'b1;
        @(posedge clk); @(posedge clk);
        #2 reset = 1'b1;
        #1;
        n_cmp++; if (mem_ready !== 1'b0) begin n_fail++; $display("FAIL midrst_ready got=%b exp=0", mem_ready); end
        n_cmp++; if (rdata !== 32'd0) begin n_fail++; $display("FAIL midrst_rdata got=%h exp=0", rdata); end
        write_mem = 1'b0;
        m_rdata = 32'd0; m_err = 1'b0;
        @(negedge clk); reset = 1'b0;
        acc(0, 1, 32'h20, 0, 0, 0, lat); model_op(0, 32'h20, 0);
        n_cmp++; if (lat != WC + 2) begin n_fail++; $display("FAIL midrst_latency got=%0d exp=%0d", lat, WC + 2); end
        n_cmp++; if (rdata !== 32'h11112222) begin n_fail++; $display("FAIL midrst_prewrite got=%h exp=11112222", rdata); end
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back();
        int lat;
        logic [31:0] v1, v2;
        v1 = $urandom; v2 = $urandom;
        acc0(1, 32'h1, v1, lat);
        n_cmp++; if (lat != 2) begin n_fail++; $display("FAIL w0_wr_latency got=%0d exp=2", lat); end
        @(posedge clk); #1;
        acc0(1, 32'h2, v2, lat);
        @(posedge clk); #1;
        acc0(0, 32'h1, 0, lat);
        n_cmp++; if (lat != 2) begin n_fail++; $display("FAIL w0_rd1_latency got=%0d exp=2", lat); end
        n_cmp++; if (rdata0 !== v1) begin n_fail++; $display("FAIL w0_rd1_data got=%h exp=%h", rdata0, v1); end
        @(posedge clk); #1;
        acc0(0, 32'h2, 0, lat);
        n_cmp++; if (lat != 2) begin n_fail++; $display("FAIL w0_rd2_latency got=%0d exp=2", lat); end
        n_cmp++; if (rdata0 !== v2) begin n_fail++; $display("FAIL w0_rd2_data got=%h exp=%h", rdata0, v2); end
        n_cmp++; if (err0 !== 1'b0) begin n_fail++; $display("FAIL w0_err got=%b exp=0", err0); end
        @(posedge clk); #1;
    endtask

    initial begin
        reset = 1'b1;
        Read = 0; write_mem = 0; MAR = 0; wdata = 0;
        Read0 = 0; write0 = 0; MAR0 = 0; wdata0 = 0;
        for (int i = 0; i < DEPTH; i++) begin m_mem[i] = 32'd0; m_known[i] = 1'b0; end
        m_rdata = 32'd0; m_rknown = 1'b1; m_err = 1'b0;
        test_reset();
        test_write_read();
        test_hold();
        test_random();
        test_out_of_range();
        test_both();
        test_reset_midaccess();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
